hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/forward_select.sv | 29 ++
 rtl/hazard_controller.sv | 125 ++++++++++++
 tb/tb_hazard_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: action encoding, forward-select codes
// and the shadow pipeline entry layouts.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_FREEZE     = 2'd3
  } action_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } entry_t;

  typedef struct packed {
    entry_t     base;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
  } ex_entry_t;

endpackage

// File: rtl/forward_select.sv
// Chooses the EX operand source for one source register: MEM result beats WB
// data, and x0 is never forwarded.
module forward_select
  import hazard_pkg::*;
(
  input  logic       uses,
  input  logic [4:0] rs,
  input  entry_t     mem_entry,
  input  entry_t     wb_entry,
  output logic [1:0] fwd
);

  logic mem_hit;
  logic wb_hit;
  logic unused_bits;

  assign mem_hit = uses && mem_entry.valid && mem_entry.reg_write &&
                   (mem_entry.rd != 5'd0) && (mem_entry.rd == rs);
  assign wb_hit  = uses && wb_entry.valid && wb_entry.reg_write &&
                   (wb_entry.rd != 5'd0) && (wb_entry.rd == rs);
  assign unused_bits = mem_entry.mem_read ^ wb_entry.mem_read;

  always_comb begin
    fwd = FWD_REG;
    if (mem_hit)     fwd = FWD_MEM;
    else if (wb_hit) fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: tracks EX/MEM/WB in a shadow pipeline and derives
// stall, flush, freeze and forwarding controls for a five-stage core.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         idValid,
  input  logic [4:0]                   idRs1,
  input  logic [4:0]                   idRs2,
  input  logic                         idUsesRs1,
  input  logic                         idUsesRs2,
  input  logic [4:0]                   idRd,
  input  logic                         idRegWrite,
  input  logic                         idMemRead,
  input  logic                         exBranchTaken,
  input  logic                         memBusy,
  output logic                         pcWrite,
  output logic                         ifIdWrite,
  output logic                         ifIdFlush,
  output logic                         idExBubble,
  output logic [1:0]                   forwardA,
  output logic [1:0]                   forwardB,
  output logic [1:0]                   state,
  output logic [STALL_COUNT_WIDTH-1:0] stallCount
);

  ex_entry_t                    ex_p0;
  entry_t                       mem_p1;
  entry_t                       wb_p2;
  action_t                      action;
  action_t                      state_q;
  logic                         load_use;
  logic [STALL_COUNT_WIDTH-1:0] stall_cnt_q;

  assign load_use = idValid && ex_p0.base.valid && ex_p0.base.mem_read &&
                    (ex_p0.base.rd != 5'd0) &&
                    ((idUsesRs1 && (idRs1 == ex_p0.base.rd)) ||
                     (idUsesRs2 && (idRs2 == ex_p0.base.rd)));

  // A taken branch outranks a load-use stall: the stalled ID op is wrong-path anyway.
  always_comb begin
    action = ST_RUN;
    if (memBusy)            action = ST_FREEZE;
    else if (exBranchTaken) action = ST_FLUSH;
    else if (load_use)      action = ST_LOAD_STALL;
  end

  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    unique case (action)
      ST_FREEZE: begin
        pcWrite   = 1'b0;
        ifIdWrite = 1'b0;
      end
      ST_FLUSH: begin
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
      end
      ST_LOAD_STALL: begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= action;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_q <= '0;
    else if ((action != ST_RUN) && (stall_cnt_q != {STALL_COUNT_WIDTH{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  // Shadow pipeline: only the valid bits are reset; payload fields follow valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_p0.base.valid <= 1'b0;
      mem_p1.valid     <= 1'b0;
      wb_p2.valid      <= 1'b0;
    end else if (action != ST_FREEZE) begin
      wb_p2                <= mem_p1;
      mem_p1               <= ex_p0.base;
      ex_p0.base.valid     <= idValid && !idExBubble;
      ex_p0.base.rd        <= idRd;
      ex_p0.base.reg_write <= idRegWrite;
      ex_p0.base.mem_read  <= idMemRead;
      ex_p0.rs1            <= idRs1;
      ex_p0.rs2            <= idRs2;
      ex_p0.uses_rs1       <= idUsesRs1;
      ex_p0.uses_rs2       <= idUsesRs2;
    end
  end

  forward_select u_fwd_a (
    .uses      (ex_p0.uses_rs1),
    .rs        (ex_p0.rs1),
    .mem_entry (mem_p1),
    .wb_entry  (wb_p2),
    .fwd       (forwardA)
  );

  forward_select u_fwd_b (
    .uses      (ex_p0.uses_rs2),
    .rs        (ex_p0.rs2),
    .mem_entry (mem_p1),
    .wb_entry  (wb_p2),
    .fwd       (forwardB)
  );

  assign state      = state_q;
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: load-use stall, forwarding priority, x0,
// branch/freeze interaction, counter saturation and reset mid-stall.
module tb_hazard_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          idValid;
  logic [4:0]    idRs1;
  logic [4:0]    idRs2;
  logic          idUsesRs1;
  logic          idUsesRs2;
  logic [4:0]    idRd;
  logic          idRegWrite;
  logic          idMemRead;
  logic          exBranchTaken;
  logic          memBusy;
  logic          pcWrite;
  logic          ifIdWrite;
  logic          ifIdFlush;
  logic          idExBubble;
  logic [1:0]    forwardA;
  logic [1:0]    forwardB;
  logic [1:0]    state;
  logic [CW-1:0] stallCount;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_controller #(.STALL_COUNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .idValid       (idValid),
    .idRs1         (idRs1),
    .idRs2         (idRs2),
    .idUsesRs1     (idUsesRs1),
    .idUsesRs2     (idUsesRs2),
    .idRd          (idRd),
    .idRegWrite    (idRegWrite),
    .idMemRead     (idMemRead),
    .exBranchTaken (exBranchTaken),
    .memBusy       (memBusy),
    .pcWrite       (pcWrite),
    .ifIdWrite     (ifIdWrite),
    .ifIdFlush     (ifIdFlush),
    .idExBubble    (idExBubble),
    .forwardA      (forwardA),
    .forwardB      (forwardB),
    .state         (state),
    .stallCount    (stallCount)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    idValid    = v;
    idRs1      = rs1;
    idUsesRs1  = u1;
    idRs2      = rs2;
    idUsesRs2  = u2;
    idRd       = rd;
    idRegWrite = rw;
    idMemRead  = mr;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    memBusy       = 1'b0;
    exBranchTaken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
  endtask

  task automatic check_ctrl(input string tag, input logic pc, input logic ifid,
                            input logic fl, input logic bub);
    check_vec({tag, ".pcWrite"},    pcWrite,    pc);
    check_vec({tag, ".ifIdWrite"},  ifIdWrite,  ifid);
    check_vec({tag, ".ifIdFlush"},  ifIdFlush,  fl);
    check_vec({tag, ".idExBubble"}, idExBubble, bub);
  endtask

  initial begin
    // Reset held while memBusy and a branch are active still clears everything
    reset         = 1'b1;
    memBusy       = 1'b1;
    exBranchTaken = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check_vec("rst.state", state, 2'd0);
    check_vec("rst.count", stallCount, 0);
    reset         = 1'b0;
    memBusy       = 1'b0;
    exBranchTaken = 1'b0;
    #2;
    check_ctrl("rst.out", 1, 1, 0, 0);
    check_vec("rst.fwdA", forwardA, 2'b00);
    check_vec("rst.fwdB", forwardB, 2'b00);

    // Load-use: lw x5 then add x6,x5,x1
    do_reset();
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
    #2 check_vec("lu.lw_issue", pcWrite, 1);
    step();
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    #2 check_ctrl("lu.stall", 0, 0, 0, 1);
    step();
    check_vec("lu.state", state, 2'd1);
    check_vec("lu.count", stallCount, 1);
    #2 check_ctrl("lu.release", 1, 1, 0, 0);
    step();
    check_vec("lu.state_run", state, 2'd0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_vec("lu.fwdA", forwardA, 2'b01);
    check_vec("lu.fwdB", forwardB, 2'b00);

    // Double forward: MEM match beats WB match
    do_reset();
    set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);
    step();
    set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);
    step();
    set_id(1, 5'd3, 1, 5'd0, 1, 5'd7, 1, 0);
    step();
    set_id(1, 5'd3, 1, 5'd7, 1, 5'd8, 1, 0);
    #2;
    check_vec("df.fwdA_mem", forwardA, 2'b10);
    check_vec("df.fwdB_x0", forwardB, 2'b00);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_vec("df.fwdA_wb", forwardA, 2'b01);
    check_vec("df.fwdB_mem", forwardB, 2'b10);

    // x0 everywhere: no forward, no stall
    do_reset();
    set_id(1, 0, 0, 0, 0, 5'd0, 1, 0);
    step();
    set_id(1, 0, 0, 0, 0, 5'd0, 1, 0);
    step();
    set_id(1, 0, 0, 0, 0, 5'd0, 1, 1);
    step();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0);
    #2 check_ctrl("x0.nostall", 1, 1, 0, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_vec("x0.fwdA", forwardA, 2'b00);
    check_vec("x0.fwdB", forwardB, 2'b00);
    check_vec("x0.state", state, 2'd0);

    // Branch together with load-use hazard: flush wins
    do_reset();
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
    step();
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    exBranchTaken = 1'b1;
    #2 check_ctrl("br.flush", 1, 1, 1, 1);
    step();
    exBranchTaken = 1'b0;
    check_vec("br.state", state, 2'd2);
    check_vec("br.count", stallCount, 1);

    // Freeze for three cycles with a branch held in EX, then flush
    do_reset();
    set_id(1, 0, 0, 0, 0, 5'd4, 1, 0);
    step();
    set_id(1, 5'd4, 1, 5'd0, 0, 5'd9, 1, 0);
    step();
    set_id(1, 5'd9, 0, 5'd0, 0, 5'd10, 1, 0);
    memBusy       = 1'b1;
    exBranchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_ctrl("fz.frozen", 0, 0, 0, 0);
      check_vec("fz.fwdA_held", forwardA, 2'b10);
      step();
      check_vec("fz.state", state, 2'd3);
    end
    memBusy = 1'b0;
    #2 check_ctrl("fz.flush", 1, 1, 1, 1);
    step();
    exBranchTaken = 1'b0;
    check_vec("fz.state_flush", state, 2'd2);
    check_vec("fz.count", stallCount, 4);

    // Saturation after 20 non-RUN cycles, then reset during a load-use stall
    do_reset();
    memBusy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_vec("sat.count", stallCount, 15);
    memBusy = 1'b0;
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
    #2 check_vec("sat.lw_issue", pcWrite, 1);
    step();
    check_vec("sat.count_hold", stallCount, 15);
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    #2 check_vec("sat.stall", idExBubble, 1);
    reset = 1'b1;
    step();
    check_vec("rs.state", state, 2'd0);
    check_vec("rs.count", stallCount, 0);
    reset = 1'b0;
    #2 check_ctrl("rs.no_bubble", 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
